// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter sharing one pattern FSM among N requesters.
// Ports: clk, reset (async high); req/last/din per requester in;
//   gnt (one-hot), owner, busy, shared_data_in, shared_clr out;
//   grants_total (8b, saturating) only when FSM_ARB_STATS_EN is defined.
module fsm_rr_arbiter #(
  parameter int N         = 4,
  parameter int IDX_W     = 2,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     last,
  input  logic [N-1:0]     din,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] owner,
  output logic             busy,
  output logic             shared_data_in,
  output logic             shared_clr
`ifdef FSM_ARB_STATS_EN
  ,
  output logic [7:0]       grants_total
`endif
);

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_ARB   = 3'b001;
  localparam logic [2:0] S_GRANT = 3'b010;
  localparam logic [2:0] S_FLUSH = 3'b100;

  logic [2:0]       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sdi_q, sdi_d;
  logic             clr_q, clr_d;
`ifdef FSM_ARB_STATS_EN
  logic [7:0]       tot_q, tot_d;
`endif

  logic [2*N-1:0]   rot;
  logic             found;
  logic [IDX_W-1:0] win;
  logic             burst_end;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sdi_d   = 1'b0;
    clr_d   = 1'b0;
`ifdef FSM_ARB_STATS_EN
    tot_d   = tot_q;
`endif
    // Rotate so bit 0 is the requester at ptr; first set bit wins.
    rot   = {req, req} >> ptr_q;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        win   = IDX_W'((int'(ptr_q) + k) % N);
      end
    end
    burst_end = last[owner_q] | ~req[owner_q]
              | (cnt_q == CNT_W'(MAX_BURST - 1));
    unique case (1'b1)
      (state_q == S_IDLE): begin
        gnt_d = '0;
        if (|req) state_d = S_ARB;
      end
      (state_q == S_ARB): begin
        if (found) begin
          owner_d = win;
          gnt_d   = N'(1) << win;
          cnt_d   = '0;
          state_d = S_GRANT;
`ifdef FSM_ARB_STATS_EN
          if (tot_q != 8'hFF) tot_d = tot_q + 8'd1;
`endif
        end else begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      (state_q == S_GRANT): begin
        if (burst_end) begin
          gnt_d   = '0;
          clr_d   = 1'b1;
          ptr_d   = IDX_W'((int'(owner_q) + 1) % N);
          state_d = S_FLUSH;
        end else begin
          sdi_d = din[owner_q];
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      (state_q == S_FLUSH): begin
        gnt_d   = '0;
        state_d = (|req) ? S_ARB : S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sdi_q   <= 1'b0;
      clr_q   <= 1'b0;
`ifdef FSM_ARB_STATS_EN
      tot_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sdi_q   <= sdi_d;
      clr_q   <= clr_d;
`ifdef FSM_ARB_STATS_EN
      tot_q   <= tot_d;
`endif
    end
  end

  assign gnt            = gnt_q;
  assign owner          = owner_q;
  assign shared_data_in = sdi_q;
  assign shared_clr     = clr_q;
  assign busy           = (state_q == S_ARB) || (state_q == S_GRANT)
                       || (state_q == S_FLUSH);
`ifdef FSM_ARB_STATS_EN
  assign grants_total   = tot_q;
`endif

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Self-checking bench for fsm_rr_arbiter.
// Behavioural model plus directed scenarios with literal expectations.
module tb_fsm_rr_arbiter;
  localparam int N = 4;
  localparam int MAXB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, last, din;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy, sdi, clr;
`ifdef FSM_ARB_STATS_EN
  logic [7:0] grants_total;
`endif

  fsm_rr_arbiter #(.N(4), .IDX_W(2), .MAX_BURST(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .din(din),
    .gnt(gnt), .owner(owner), .busy(busy),
    .shared_data_in(sdi), .shared_clr(clr)
`ifdef FSM_ARB_STATS_EN
    , .grants_total(grants_total)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_ARB = 1, P_GRANT = 2, P_FLUSH = 3;
  int   ph = P_IDLE;
  int   e_gnt = 0, e_own = 0, e_sdi = 0, e_clr = 0;
  int   m_ptr = 0, m_used = 0, m_tot = 0;
  int   m_idx;
  bit   m_found;
  bit   bad_flag;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = P_IDLE; e_gnt = 0; e_own = 0; e_sdi = 0; e_clr = 0;
      m_ptr = 0; m_used = 0; m_tot = 0;
    end else if (bad_flag) begin
      ph = P_IDLE; e_gnt = 0; e_sdi = 0; e_clr = 0;
    end else begin
      case (ph)
        P_IDLE: begin
          e_gnt = 0; e_sdi = 0; e_clr = 0;
          if (req != 0) ph = P_ARB;
        end
        P_ARB: begin
          e_sdi = 0; e_clr = 0; m_found = 0;
          for (int k = 0; k < N; k++) begin
            m_idx = (m_ptr + k) % N;
            if (!m_found && req[m_idx]) begin
              m_found = 1; e_own = m_idx;
            end
          end
          if (m_found) begin
            e_gnt = 1 << e_own; m_used = 0; ph = P_GRANT;
            if (m_tot < 255) m_tot++;
          end else begin
            e_gnt = 0; ph = P_IDLE;
          end
        end
        P_GRANT: begin
          m_used++;
          if (last[e_own] || !req[e_own] || m_used == MAXB) begin
            e_gnt = 0; e_clr = 1; e_sdi = 0;
            m_ptr = (e_own + 1) % N; ph = P_FLUSH;
          end else begin
            e_sdi = int'(din[e_own]);
          end
        end
        default: begin
          e_gnt = 0; e_sdi = 0; e_clr = 0;
          ph = (req != 0) ? P_ARB : P_IDLE;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("cmp_gnt", int'(gnt), e_gnt);
    chk("cmp_owner", int'(owner), e_own);
    chk("cmp_busy", int'(busy),
        (!bad_flag && ph != P_IDLE) ? 1 : 0);
    chk("cmp_sdi", int'(sdi), e_sdi);
    chk("cmp_clr", int'(clr), e_clr);
`ifdef FSM_ARB_STATS_EN
    chk("cmp_total", int'(grants_total), m_tot);
`endif
  end

  // ---------------- grant activity monitor ----------------
  int own_q[$], len_q[$], gap_q[$];
  int run_len = 0, gap_len = 0, clr_cnt = 0;
  bit seen = 0;
  logic [3:0] prev_g = '0;

  always @(negedge clk) begin
    if (gnt != 0) begin
      if (prev_g == 0) begin
        own_q.push_back(int'(owner));
        if (seen) gap_q.push_back(gap_len);
        seen = 1; run_len = 0;
      end
      run_len++;
    end else begin
      if (prev_g != 0) begin
        len_q.push_back(run_len); gap_len = 1;
      end else begin
        gap_len++;
      end
    end
    if (clr) clr_cnt++;
    prev_g = gnt;
  end

  task automatic clear_mon();
    own_q.delete(); len_q.delete(); gap_q.delete();
    clr_cnt = 0; seen = 0; gap_len = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_for_gnt(input logic [3:0] g, input string nm);
    int k = 0;
    while (gnt !== g && k < 100) begin tick(); k++; end
    chk(nm, int'(gnt), int'(g));
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 100) begin tick(); k++; end
    chk(nm, int'(busy), 0);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int s0, s1, s2;

  initial begin
    reset = 1; req = 0; last = 0; din = 0; bad_flag = 0;
    tick(); tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_clr", int'(clr), 0);
    chk("rst_sdi", int'(sdi), 0);
    reset = 0;
    tick();

    // single requester, last on 3rd grant cycle
    clear_mon();
    req = 4'b0001;
    tick();
    chk("t1_arb_gnt", int'(gnt), 0);
    chk("t1_arb_busy", int'(busy), 1);
    tick();
    chk("t1_lat_gnt", int'(gnt), 1);
    tick(); tick();
    last = 4'b0001;
    tick();
    chk("t1_flush_clr", int'(clr), 1);
    chk("t1_flush_gnt", int'(gnt), 0);
    last = 0; req = 0;
    tick();
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_idle_clr", int'(clr), 0);
    chk("t1_burst_len", (len_q.size() == 1) ? len_q[0] : -1, 3);
    chk("t1_clr_pulses", clr_cnt, 1);

    // all requesting, full bursts
    reset = 1; tick(); reset = 0;
    clear_mon();
    req = 4'hF;
    for (int k = 0; k < 300 && own_q.size() < 5; k++) tick();
    chk("t2_grants_seen", own_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < own_q.size())
        chk($sformatf("t2_owner%0d", i), own_q[i], exp_order[i]);
    for (int i = 0; i < 4; i++) begin
      if (i < len_q.size())
        chk($sformatf("t2_len%0d", i), len_q[i], MAXB);
      if (i < gap_q.size())
        chk($sformatf("t2_gap%0d", i), gap_q[i], 2);
    end
    chk("t2_clr_pulses", clr_cnt, 4);
    req = 0;
    wait_idle("t2_idle");

    // data forwarding from owner 2
    req = 4'b0100;
    wait_for_gnt(4'b0100, "t3_gnt2");
    din = 4'b0100; tick(); s0 = int'(sdi);
    din = 4'b0001; tick(); s1 = int'(sdi);
    din = 4'b0100; tick(); s2 = int'(sdi);
    din = 0;
    chk("t3_sdi0", s0, 1);
    chk("t3_sdi1", s1, 0);
    chk("t3_sdi2", s2, 1);
    req = 0;
    wait_idle("t3_idle");

    // withdrawal during ARB
    tick();
    clear_mon();
    req = 4'b0010;
    tick();
    chk("t4_arb_busy", int'(busy), 1);
    req = 0;
    tick();
    chk("t4_idle_busy", int'(busy), 0);
    chk("t4_idle_gnt", int'(gnt), 0);
    tick();
    chk("t4_no_clr", clr_cnt, 0);
    chk("t4_no_grant", own_q.size(), 0);

    // illegal state recovery
    req = 4'b0001;
    wait_for_gnt(4'b0001, "t5_gnt0");
    tick();
    bad_flag = 1;
    force dut.state_q = 3'b011;
    #1;
    release dut.state_q;
    chk("t5_bad_busy", int'(busy), 0);
    tick();
    bad_flag = 0;
    chk("t5_rec_gnt", int'(gnt), 0);
    chk("t5_rec_clr", int'(clr), 0);
    chk("t5_rec_sdi", int'(sdi), 0);
    chk("t5_rec_busy", int'(busy), 0);

    // async reset mid-GRANT, pointer restarts at 0
    req = 4'hF;
    wait_for_gnt(4'b1000, "t5_gnt3");
    tick();
    reset = 1;
    #1;
    chk("t5_rst_gnt", int'(gnt), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_clr", int'(clr), 0);
    chk("t5_rst_sdi", int'(sdi), 0);
    req = 4'b1110;
    tick();
    reset = 0;
    wait_for_gnt(4'b0010, "t5_post_gnt1");
    chk("t5_post_owner", int'(owner), 1);
    req = 0;
    wait_idle("t5_idle");

`ifdef FSM_ARB_STATS_EN
    clear_mon();
    req = 4'b0001; last = 4'b0001;
    for (int k = 0; k < 3000 && own_q.size() < 300; k++) tick();
    chk("t6_bursts", own_q.size(), 300);
    req = 0; last = 0;
    wait_idle("t6_idle");
    chk("t6_total", int'(grants_total), 255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fsm_rr_arbiter.md
Name: fsm_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one instance of the team's 4-state pattern FSM (single-bit data_in, asynchronous reset) between N requesters. It grants the shared FSM to one requester at a time for a bounded burst. During the burst it forwards that requester's data bit to the FSM. Between owners it issues a one-cycle clear pulse so every new owner starts from the FSM reset state. The arbiter's own state register is safe-encoded, so any illegal state recovers to IDLE.

Parameters:
N, 4, number of requesters (2..8)
IDX_W, 2, width of owner index; must satisfy 2**IDX_W >= N
MAX_BURST, 8, maximum GRANT cycles per ownership (1..255)
CNT_W, 8, burst counter width; must hold MAX_BURST-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  N  per-requester request, level; held until served or withdrawn
last  input  N  per-requester end-of-burst marker, sampled only for the current owner
din  input  N  per-requester data bit for the shared FSM
gnt  output  N  one-hot grant, registered
owner  output  IDX_W  index of current or most recent owner, registered
busy  output  1  high in ARB, GRANT and FLUSH
shared_data_in  output  1  drives shared FSM data_in, registered
shared_clr  output  1  one-cycle clear pulse to the shared FSM reset input, registered

Behaviour:
- Reset values: state=IDLE, gnt=0, owner=0, busy=0, shared_data_in=0, shared_clr=0, rr pointer ptr=0, burst_cnt=0.
- State register: 3 bits. IDLE=000, ARB=001, GRANT=010, FLUSH=100. Any other encoding goes to IDLE on the next edge with gnt=0, shared_clr=0, shared_data_in=0.
- IDLE: if any req bit is high, go to ARB. Otherwise stay. All outputs are 0 except owner, which holds.
- ARB: choose the first i with req[i]=1, scanning ptr, ptr+1, ... with wrap at N.
  - If a requester is found: owner<=i, gnt<=onehot(i), burst_cnt<=0, go to GRANT.
  - If no req bit is high (all withdrawn), go to IDLE with no grant.
- GRANT (every cycle):
  - gnt stays at onehot(owner).
  - shared_data_in<=din[owner], so shared_data_in lags din by one cycle.
  - burst_cnt increments.
  - Exit to FLUSH when last[owner]=1, or req[owner]=0, or burst_cnt==MAX_BURST-1. Whichever fires first wins. If several fire in the same cycle, exactly one FLUSH occurs.
  - On exit: gnt<=0, shared_clr<=1, shared_data_in<=0, ptr<=(owner+1) mod N.
- FLUSH: lasts exactly one cycle, and shared_clr is high for exactly this cycle. Next state is ARB if any req bit is high, otherwise IDLE.
- Latency:
  - req rising while IDLE: gnt is visible 2 edges later.
  - Owner-to-owner handover: 2 cycles with gnt=0 (FLUSH, ARB).
- Fairness: a requester that holds req continuously is granted within N-1 other bursts.
- req changes from non-owners during GRANT are ignored until the next ARB.
- Reset asserted mid-GRANT: gnt, shared_clr and shared_data_in drop asynchronously. After reset releases, arbitration restarts from ptr=0.
- Bits of last and din outside the owner are don't-care.

Optional Feature:
Macro: FSM_ARB_STATS_EN
- Defined: adds output grants_total (8 bits). It increments on each ARB→GRANT transition and saturates at 255. It resets to 0 on reset.
- Not defined: the port is absent and there is no counter logic.
- Arbitration timing is identical in both builds.

Test Plan:
- Reset, then req=0001 with last[0] pulsed on the 3rd GRANT cycle → gnt=0001 two edges after req; exactly 3 GRANT cycles; shared_clr one cycle; return to IDLE.
- req=1111 held, last never asserted, MAX_BURST=8 → grants in order 0,1,2,3,0. Each burst is 8 cycles. Each handover has 2 gnt=0 cycles and a single shared_clr pulse.
- Owner 2 in GRANT with din[2]=1,0,1 → shared_data_in=1,0,1 delayed by one cycle. Toggling din[0] has no effect.
- req[1] withdrawn in ARB with no other req bit high → IDLE, gnt stays 0, no shared_clr.
- Force the state register to 011 → next edge is IDLE with all outputs 0. Separately, assert reset mid-GRANT → gnt=0 immediately, and after release the first grant goes to the lowest-index requester.
- With FSM_ARB_STATS_EN defined: 300 single-cycle bursts → grants_total=255.
